// File: rtl/eq_chnnl_sched.sv
// Time-multiplexes stereo pairs through one filter engine: left, then right, then one aligned output pair.
// Optional engine watchdog enabled by `define SCHED_TMO_EN (bypasses the sample and sets flt_err on timeout).
module eq_chnnl_sched #(
    parameter int DW  = 24,
    parameter int TMO = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld_in,
    input  logic [DW-1:0] i_lft_in,
    input  logic [DW-1:0] i_rght_in,
    output logic          o_flt_start,
    output logic          o_flt_sel,
    output logic [DW-1:0] o_flt_smpl,
    input  logic          i_flt_done,
    input  logic [DW-1:0] i_flt_rslt,
    output logic [DW-1:0] o_lft_out,
    output logic [DW-1:0] o_rght_out,
    output logic          o_out_vld,
    output logic          o_busy,
    output logic          o_ovrn,
    output logic          o_flt_err,
    input  logic          i_clr_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_L_REQ, S_L_WAIT, S_R_REQ, S_R_WAIT, S_OUT
    } state_t;

    state_t        r_state;
    logic          r_pend_vld;
    logic [DW-1:0] r_pend_l, r_pend_r;
    logic [DW-1:0] r_work_l, r_work_r;
    logic [DW-1:0] r_res_l;
    logic [DW-1:0] r_lft_out, r_rght_out;
    logic          r_ovrn;

    logic          w_consume;
    logic          w_drop;
    logic          w_in_wait;
    logic          w_tmo;
    logic          w_adv;
    logic [DW-1:0] w_res;

    assign w_consume = (r_state == S_IDLE) && r_pend_vld;
    assign w_drop    = i_vld_in && r_pend_vld && !w_consume;
    assign w_in_wait = (r_state == S_L_WAIT) || (r_state == S_R_WAIT);

`ifdef SCHED_TMO_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_flt_err;

    assign w_tmo = w_in_wait && (r_tmo_cnt == TW'(TMO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_flt_err <= 1'b0;
        end else begin
            if ((r_state == S_L_REQ) || (r_state == S_R_REQ))
                r_tmo_cnt <= '0;
            else if (w_in_wait)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            // A late done arriving on the timeout cycle is still a valid result.
            if (w_tmo && !i_flt_done)
                r_flt_err <= 1'b1;
            else if (i_clr_err)
                r_flt_err <= 1'b0;
        end
    end

    assign o_flt_err = r_flt_err;
`else
    assign w_tmo     = 1'b0;
    assign o_flt_err = 1'b0;
`endif

    assign w_adv = i_flt_done || w_tmo;
    assign w_res = (w_tmo && !i_flt_done) ? ((r_state == S_R_WAIT) ? r_work_r : r_work_l)
                                          : i_flt_rslt;

    // One-deep input buffer; a slot freed this cycle may be refilled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_l   <= '0;
            r_pend_r   <= '0;
            r_ovrn     <= 1'b0;
        end else begin
            if (i_vld_in && (!r_pend_vld || w_consume)) begin
                r_pend_l   <= i_lft_in;
                r_pend_r   <= i_rght_in;
                r_pend_vld <= 1'b1;
            end else if (w_consume) begin
                r_pend_vld <= 1'b0;
            end
            if (w_drop)
                r_ovrn <= 1'b1;
            else if (i_clr_err)
                r_ovrn <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_work_l   <= '0;
            r_work_r   <= '0;
            r_res_l    <= '0;
            r_lft_out  <= '0;
            r_rght_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pend_vld) begin
                        r_work_l <= r_pend_l;
                        r_work_r <= r_pend_r;
                        r_state  <= S_L_REQ;
                    end
                end
                S_L_REQ:  r_state <= S_L_WAIT;
                S_L_WAIT: begin
                    if (w_adv) begin
                        r_res_l <= w_res;
                        r_state <= S_R_REQ;
                    end
                end
                S_R_REQ:  r_state <= S_R_WAIT;
                S_R_WAIT: begin
                    if (w_adv) begin
                        r_lft_out  <= r_res_l;
                        r_rght_out <= w_res;
                        r_state    <= S_OUT;
                    end
                end
                S_OUT:    r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_flt_smpl = '0;
        case (r_state)
            S_L_REQ, S_L_WAIT: o_flt_smpl = r_work_l;
            S_R_REQ, S_R_WAIT: o_flt_smpl = r_work_r;
            default:           o_flt_smpl = '0;
        endcase
    end

    assign o_flt_start = (r_state == S_L_REQ) || (r_state == S_R_REQ);
    assign o_flt_sel   = (r_state == S_R_REQ) || (r_state == S_R_WAIT);
    assign o_out_vld   = (r_state == S_OUT);
    assign o_busy      = (r_state != S_IDLE) || r_pend_vld;
    assign o_ovrn      = r_ovrn;
    assign o_lft_out   = r_lft_out;
    assign o_rght_out  = r_rght_out;

endmodule

// File: tb/tb_eq_chnnl_sched.sv
// Bench for eq_chnnl_sched: directed steps plus random pairs against a cycle-arithmetic scheduling model.
`timescale 1ns/1ps
module tb_eq_chnnl_sched;
    localparam int DW     = 24;
    localparam int TMO_TB = 15;
    localparam int INF    = 1 << 30;

    typedef struct {
        int            cyc;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_vld_in;
    logic [DW-1:0] i_lft_in, i_rght_in;
    logic          o_flt_start, o_flt_sel;
    logic [DW-1:0] o_flt_smpl;
    logic          i_flt_done;
    logic [DW-1:0] i_flt_rslt;
    logic [DW-1:0] o_lft_out, o_rght_out;
    logic          o_out_vld, o_busy, o_ovrn, o_flt_err;
    logic          i_clr_err;

    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_rslt = '0;
    logic          stray_done;
    logic [DW-1:0] stray_rslt;
    assign i_flt_done = eng_done | stray_done;
    assign i_flt_rslt = eng_done ? eng_rslt : stray_rslt;

    eq_chnnl_sched #(.DW(DW), .TMO(TMO_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_vld_in(i_vld_in), .i_lft_in(i_lft_in), .i_rght_in(i_rght_in),
        .o_flt_start(o_flt_start), .o_flt_sel(o_flt_sel), .o_flt_smpl(o_flt_smpl),
        .i_flt_done(i_flt_done), .i_flt_rslt(i_flt_rslt),
        .o_lft_out(o_lft_out), .o_rght_out(o_rght_out), .o_out_vld(o_out_vld),
        .o_busy(o_busy), .o_ovrn(o_ovrn), .o_flt_err(o_flt_err), .i_clr_err(i_clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine behaviour: 0 none, 1 stall both, 2 stall right, 3 stall left.
    int eng_stall = 0;
    int eng_fixed = 0;

    function automatic int lat_of(input logic [DW-1:0] x);
        return (eng_fixed != 0) ? eng_fixed : 1 + int'(x[2:0]);
    endfunction

    function automatic bit stalled(input logic sel);
        return (eng_stall == 1) || (eng_stall == 2 && sel) || (eng_stall == 3 && !sel);
    endfunction

    bit            e_act = 1'b0;
    int            e_due = 0;
    logic [DW-1:0] e_res = '0;
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (!rst_n) begin
            e_act = 1'b0;
        end else begin
            if (e_act && cyc == e_due) begin
                eng_done = 1'b1;
                eng_rslt = e_res;
                e_act    = 1'b0;
            end
            if (o_flt_start && !stalled(o_flt_sel)) begin
                e_act = 1'b1;
                e_due = cyc + lat_of(o_flt_smpl);
                e_res = o_flt_smpl + 1'b1;
            end
        end
    end

    pair_t obs_q[$];
    always @(negedge clk)
        if (rst_n && o_out_vld) obs_q.push_back('{cyc, o_lft_out, o_rght_out});

    // Reference model: pending slot holds a pair until the cycle the idle scheduler takes it;
    // a taken pair emits 3 + latL + latR cycles later and frees the scheduler one cycle after that.
    pair_t exp_q[$];
    int    m_free = 0;
    int    m_c    = 0;
    bit    exp_ovrn = 1'b0;

    task automatic chan(input logic [DW-1:0] x, input logic sel,
                        output int lat, output logic [DW-1:0] res, output bit lost);
        lost = 1'b0;
        lat  = lat_of(x);
        res  = x + 1'b1;
        if (stalled(sel)) begin
`ifdef SCHED_TMO_EN
            lat = TMO_TB + 1;
            res = x;
`else
            lost = 1'b1;
`endif
        end
    endtask

    task automatic model_vld(input int v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        int c, ll, lr, o;
        logic [DW-1:0] rl, rr;
        bit lost;
        if (v < m_c) begin
            exp_ovrn = 1'b1;
            return;
        end
        c   = (v + 1 > m_free) ? v + 1 : m_free;
        m_c = c;
        chan(l, 1'b0, ll, rl, lost);
        if (lost) begin m_free = INF; return; end
        chan(r, 1'b1, lr, rr, lost);
        if (lost) begin m_free = INF; return; end
        o = c + 3 + ll + lr;
        m_free = o + 1;
        exp_q.push_back('{o, rl, rr});
    endtask

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
        i_vld_in  = 1'b1;
        i_lft_in  = l;
        i_rght_in = r;
        model_vld(cyc, l, r);
        @(negedge clk);
        i_vld_in  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (cyc > m_free) break;
            @(negedge clk);
        end
    endtask

    task automatic check_outputs(input string tag);
        pair_t e, o;
        chk({tag, " count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, " cycle"}, 64'(o.cyc), 64'(e.cyc));
            chk({tag, " lft"},   64'(o.l),   64'(e.l));
            chk({tag, " rght"},  64'(o.r),   64'(e.r));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, " busy"},    64'(o_busy),      64'd0);
        chk({tag, " out_vld"}, 64'(o_out_vld),   64'd0);
        chk({tag, " start"},   64'(o_flt_start), 64'd0);
        chk({tag, " sel"},     64'(o_flt_sel),   64'd0);
        chk({tag, " smpl"},    64'(o_flt_smpl),  64'd0);
        chk({tag, " lft"},     64'(o_lft_out),   64'd0);
        chk({tag, " rght"},    64'(o_rght_out),  64'd0);
        chk({tag, " ovrn"},    64'(o_ovrn),      64'd0);
        chk({tag, " flt_err"}, 64'(o_flt_err),   64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        exp_q.delete();
        obs_q.delete();
        m_free   = 0;
        m_c      = 0;
        exp_ovrn = 1'b0;
        eng_stall = 0;
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int v;
        rst_n = 1'b0; i_vld_in = 1'b0; i_lft_in = '0; i_rght_in = '0;
        i_clr_err = 1'b0; stray_done = 1'b0; stray_rslt = '0;
        step(3);
        reset_chk("reset");
        rst_n = 1'b1;
        step(2);

        // Single pair, 5-cycle engine returning in+1
        eng_fixed = 5;
        v = cyc;
        send(24'h100000, 24'h200000);
        chk("t1 busy", 64'(o_busy), 64'd1);
        step(1);
        chk("t1 lstart", 64'(o_flt_start), 64'd1);
        chk("t1 lsel",   64'(o_flt_sel),   64'd0);
        chk("t1 lsmpl",  64'(o_flt_smpl),  64'h100000);
        step(6);
        chk("t1 rstart", 64'(o_flt_start), 64'd1);
        chk("t1 rsel",   64'(o_flt_sel),   64'd1);
        chk("t1 rsmpl",  64'(o_flt_smpl),  64'h200000);
        drain();
        chk("t1 out cycle model", 64'(m_free - 1), 64'(v + 14));
        check_outputs("t1");

        // Back-to-back: second while busy, third on the cycle the second is taken
        eng_fixed = 4;
        send(24'h000011, 24'h000022);
        step(2);
        send(24'h000033, 24'h000044);
        for (int i = 0; i < 100 && cyc < m_c; i++) @(negedge clk);
        send(24'h000055, 24'h000066);
        drain();
        check_outputs("t2");
        chk("t2 ovrn", 64'(o_ovrn), 64'(exp_ovrn));

        // Stray flt_done in IDLE and in L_REQ must be ignored
        stray_done = 1'b1; stray_rslt = 24'hBADBAD;
        step(1);
        stray_done = 1'b0;
        step(1);
        chk("t5 idle busy",  64'(o_busy),      64'd0);
        chk("t5 idle start", 64'(o_flt_start), 64'd0);
        eng_fixed = 5;
        send(24'h0ABCDE, 24'h012345);
        step(1);
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        drain();
        check_outputs("t5");

        // Random pairs with engine latency derived from sample value
        eng_fixed = 0;
        for (int k = 0; k < 30; k++) begin
            send(DW'($urandom), DW'($urandom));
            step($urandom_range(0, 12));
        end
        drain();
        check_outputs("rand");
        chk("rand ovrn", 64'(o_ovrn), 64'(exp_ovrn));

        // Reset while in R_WAIT with a pending pair and a sticky overrun
        i_clr_err = 1'b1; step(1); i_clr_err = 1'b0; exp_ovrn = 1'b0;
        eng_stall = 2; eng_fixed = 3;
        send(24'h111111, 24'h222222);
        send(24'h333333, 24'h444444);
        send(24'h555555, 24'h666666);
        step(10);
        chk("t6 busy",  64'(o_busy),    64'd1);
        chk("t6 rwait", 64'(o_flt_sel), 64'd1);
        chk("t6 ovrn",  64'(o_ovrn),    64'(exp_ovrn));
        rst_n = 1'b0;
        #1;
        reset_chk("t6 rst");
        @(negedge clk);
        do_reset();
        send(24'h777777, 24'h888888);
        drain();
        check_outputs("t6 after");

        // Overrun with a stalled engine, then clear and clear-vs-set priority
        eng_stall = 1;
        send(24'h00A000, 24'h00B000);
        step(1);
        send(24'h00C000, 24'h00D000);
        step(1);
        send(24'h00E000, 24'h00F000);
        chk("t3 ovrn", 64'(o_ovrn), 64'(exp_ovrn));
        chk("t3 ovrn set", 64'(o_ovrn), 64'd1);
        i_clr_err = 1'b1; step(1); i_clr_err = 1'b0;
        chk("t3 clr", 64'(o_ovrn), 64'd0);
        i_clr_err = 1'b1;
        send(24'h001000, 24'h002000);
        i_clr_err = 1'b0;
        chk("t3 set wins", 64'(o_ovrn), 64'd1);
        do_reset();

        // Engine timeout on the left channel only
        eng_stall = 3; eng_fixed = 2;
`ifdef SCHED_TMO_EN
        send(24'h100000, 24'h200000);
        drain();
        check_outputs("t4 tmo");
        chk("t4 flt_err", 64'(o_flt_err), 64'd1);
        i_clr_err = 1'b1; step(1); i_clr_err = 1'b0;
        chk("t4 clr", 64'(o_flt_err), 64'd0);
        eng_stall = 0; eng_fixed = TMO_TB + 1;
        send(24'h300000, 24'h400000);
        drain();
        check_outputs("t4 tie");
        chk("t4 tie flt_err", 64'(o_flt_err), 64'd0);
`else
        send(24'h100000, 24'h200000);
        step(40);
        chk("t4 stuck busy", 64'(o_busy),      64'd1);
        chk("t4 stuck sel",  64'(o_flt_sel),   64'd0);
        chk("t4 no err",     64'(o_flt_err),   64'd0);
        chk("t4 no out",     64'(obs_q.size()), 64'd0);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
